// File: rtl/eth_pt_pkt_fifo.sv
// Store-and-forward Ethernet packet FIFO: forwards only complete, error-free frames and
// drops errored, truncated or overflowing frames whole, with saturating drop/forward counters.
module eth_pt_pkt_fifo #(
  parameter int DATA_W = 32,
  parameter int ERR_W  = 6,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 32,
  localparam int EMPTY_W = $clog2(DATA_W / 8)
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               rx_sop,
  input  logic               rx_eop,
  input  logic [EMPTY_W-1:0] rx_empty,
  input  logic [ERR_W-1:0]   rx_error,
  output logic [DATA_W-1:0]  tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_sop,
  output logic               tx_eop,
  output logic [EMPTY_W-1:0] tx_empty,
  output logic               tx_error,
  output logic [CNT_W-1:0]   fwd_cnt,
  output logic [CNT_W-1:0]   drop_err_cnt,
  output logic [CNT_W-1:0]   drop_ovf_cnt
);

  localparam int WORD_W = DATA_W + EMPTY_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] FULL_DIFF = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PKT     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [1:0] amt);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + {{(CNT_W-1){1'b0}}, amt};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  logic [WORD_W-1:0]  mem_r [DEPTH];
  logic [1:0]         state_r, state_nxt_s;
  logic [ADDR_W:0]    wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_W:0]    wr_commit_r, wr_commit_nxt_s;
  logic [ADDR_W:0]    rd_ptr_r;
  logic [ADDR_W-1:0]  wr_addr_s;
  logic               wr_en_s;
  logic [1:0]         inc_err_s;
  logic [1:0]         inc_ovf_s;
  logic               rx_ready_r;
  logic               rx_fire_s;
  logic               full_s, full_base_s, rx_err_s;
  logic               rd_en_s, tx_pop_s;
  logic [WORD_W-1:0]  rd_word_s;
  logic [DATA_W-1:0]  tx_data_r;
  logic [EMPTY_W-1:0] tx_empty_r;
  logic               tx_valid_r, tx_sop_r, tx_eop_r, last_eop_r;
  logic [CNT_W-1:0]   fwd_cnt_r, drop_err_cnt_r, drop_ovf_cnt_r;

  assign rx_fire_s   = rx_valid && rx_ready_r;
  assign rx_err_s    = (rx_error != {ERR_W{1'b0}});
  assign full_s      = ((wr_ptr_r - rd_ptr_r) == FULL_DIFF);
  assign full_base_s = ((wr_commit_r - rd_ptr_r) == FULL_DIFF);
  assign tx_pop_s    = tx_valid_r && tx_ready;
  assign rd_en_s     = (wr_commit_r != rd_ptr_r) && (!tx_valid_r || tx_ready);
  assign rd_word_s   = mem_r[rd_ptr_r[ADDR_W-1:0]];

  // Write FSM: frames start at wr_commit so a sop always rewinds any partial frame.
  always_comb begin
    state_nxt_s     = state_r;
    wr_ptr_nxt_s    = wr_ptr_r;
    wr_commit_nxt_s = wr_commit_r;
    wr_en_s         = 1'b0;
    wr_addr_s       = wr_ptr_r[ADDR_W-1:0];
    inc_err_s       = 2'd0;
    inc_ovf_s       = 2'd0;
    if (rx_fire_s) begin
      case (state_r)
        ST_IDLE, ST_PKT: begin
          if (rx_sop) begin
            inc_err_s = (state_r == ST_PKT) ? 2'd1 : 2'd0;
            if (full_base_s) begin
              wr_ptr_nxt_s = wr_commit_r;
              if (rx_eop) begin
                inc_ovf_s   = 2'd1;
                state_nxt_s = ST_IDLE;
              end else begin
                state_nxt_s = ST_DISCARD;
              end
            end else begin
              wr_en_s   = 1'b1;
              wr_addr_s = wr_commit_r[ADDR_W-1:0];
              if (rx_eop && !rx_err_s) begin
                wr_ptr_nxt_s    = wr_commit_r + PTR_ONE;
                wr_commit_nxt_s = wr_commit_r + PTR_ONE;
                state_nxt_s     = ST_IDLE;
              end else if (rx_eop) begin
                wr_ptr_nxt_s = wr_commit_r;
                inc_err_s    = inc_err_s + 2'd1;
                state_nxt_s  = ST_IDLE;
              end else begin
                wr_ptr_nxt_s = wr_commit_r + PTR_ONE;
                state_nxt_s  = ST_PKT;
              end
            end
          end else if (state_r == ST_PKT) begin
            if (full_s) begin
              wr_ptr_nxt_s = wr_commit_r;
              if (rx_eop) begin
                inc_ovf_s   = 2'd1;
                state_nxt_s = ST_IDLE;
              end else begin
                state_nxt_s = ST_DISCARD;
              end
            end else begin
              wr_en_s = 1'b1;
              if (rx_eop && !rx_err_s) begin
                wr_ptr_nxt_s    = wr_ptr_r + PTR_ONE;
                wr_commit_nxt_s = wr_ptr_r + PTR_ONE;
                state_nxt_s     = ST_IDLE;
              end else if (rx_eop) begin
                wr_ptr_nxt_s = wr_commit_r;
                inc_err_s    = 2'd1;
                state_nxt_s  = ST_IDLE;
              end else begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                state_nxt_s  = ST_PKT;
              end
            end
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (rx_eop) begin
            inc_ovf_s   = 2'd1;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DISCARD;
          end
        end
        default: begin
          wr_ptr_nxt_s = wr_commit_r;
          state_nxt_s  = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Frame storage, word = {eop, empty, data}.
  always_ff @(posedge clk_clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= {rx_eop, rx_empty, rx_data};
    end
  end

  // Write-side pointers, state and drop statistics.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r        <= ST_IDLE;
      wr_ptr_r       <= PTR_ZERO;
      wr_commit_r    <= PTR_ZERO;
      rx_ready_r     <= 1'b0;
      drop_err_cnt_r <= {CNT_W{1'b0}};
      drop_ovf_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r        <= state_nxt_s;
      wr_ptr_r       <= wr_ptr_nxt_s;
      wr_commit_r    <= wr_commit_nxt_s;
      rx_ready_r     <= 1'b1;
      drop_err_cnt_r <= sat_add(drop_err_cnt_r, inc_err_s);
      drop_ovf_cnt_r <= sat_add(drop_ovf_cnt_r, inc_ovf_s);
    end
  end

  // Read side: the registered RAM read doubles as the transmit output register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rd_ptr_r   <= PTR_ZERO;
      tx_valid_r <= 1'b0;
      tx_data_r  <= {DATA_W{1'b0}};
      tx_empty_r <= {EMPTY_W{1'b0}};
      tx_eop_r   <= 1'b0;
      tx_sop_r   <= 1'b0;
      last_eop_r <= 1'b1;
      fwd_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (rd_en_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        tx_valid_r <= 1'b1;
        tx_data_r  <= rd_word_s[DATA_W-1:0];
        tx_empty_r <= rd_word_s[DATA_W+EMPTY_W-1:DATA_W];
        tx_eop_r   <= rd_word_s[WORD_W-1];
        tx_sop_r   <= last_eop_r;
        last_eop_r <= rd_word_s[WORD_W-1];
      end else if (tx_pop_s) begin
        tx_valid_r <= 1'b0;
      end else begin
        tx_valid_r <= tx_valid_r;
      end
      fwd_cnt_r <= sat_add(fwd_cnt_r, {1'b0, tx_pop_s && tx_eop_r});
    end
  end

  assign rx_ready     = rx_ready_r;
  assign tx_data      = tx_data_r;
  assign tx_valid     = tx_valid_r;
  assign tx_sop       = tx_sop_r;
  assign tx_eop       = tx_eop_r;
  assign tx_empty     = tx_empty_r;
  assign tx_error     = 1'b0;
  assign fwd_cnt      = fwd_cnt_r;
  assign drop_err_cnt = drop_err_cnt_r;
  assign drop_ovf_cnt = drop_ovf_cnt_r;

endmodule

// File: tb/tb_eth_pt_pkt_fifo.sv
// Directed bench for eth_pt_pkt_fifo: expected beats are queued as good frames are
// driven and checked as they leave the transmit port.
module tb_eth_pt_pkt_fifo;
  localparam int DW = 32;
  localparam int EW = 2;
  localparam int RW = 6;
  localparam int AW = 6;
  localparam int CW = 32;

  typedef struct packed {
    logic          s;
    logic          eo;
    logic [EW-1:0] e;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data = '0;
  logic          rx_valid = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
  logic [EW-1:0] rx_empty = '0;
  logic [RW-1:0] rx_error = '0;
  logic          rx_ready;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_sop, tx_eop, tx_error;
  logic          tx_ready = 1'b1;
  logic [EW-1:0] tx_empty;
  logic [CW-1:0] fwd_cnt, drop_err_cnt, drop_ovf_cnt;

  beat_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    tgl = 1'b0;
  bit    held_v = 1'b0;
  beat_t held_w;

  always #5 clk = ~clk;

  eth_pt_pkt_fifo #(.DATA_W(DW), .ERR_W(RW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .rx_empty(rx_empty), .rx_error(rx_error),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty), .tx_error(tx_error),
    .fwd_cnt(fwd_cnt), .drop_err_cnt(drop_err_cnt), .drop_ovf_cnt(drop_ovf_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tgl) tx_ready = ~tx_ready;
  endtask

  task automatic send_frame(input int len, input logic [RW-1:0] err, input logic [EW-1:0] emp,
                            input bit has_eop, input bit fwd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_sop   = (i == 0);
      rx_eop   = has_eop && (i == len - 1);
      rx_data  = $urandom;
      rx_empty = rx_eop ? emp : '0;
      rx_error = rx_eop ? err : '0;
      b.s = rx_sop; b.eo = rx_eop; b.e = rx_empty; b.d = rx_data;
      if (fwd) exp_q.push_back(b);
      tick();
    end
    rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_error = '0; rx_empty = '0;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) tick();
    chk({tag, "_drained"}, exp_q.size(), 0);
    tick(); tick();
    @(negedge clk);
    chk({tag, "_idle_valid"}, tx_valid, 0);
    tick();
  endtask

  // Transmit monitor: scoreboard pops and hold-stability checks.
  always @(negedge clk) begin
    if (held_v) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_beat", {tx_sop, tx_eop, tx_empty, tx_data}, held_w);
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", exp_q.size(), 1);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("tx_beat", {tx_sop, tx_eop, tx_empty, tx_data}, e);
        chk("tx_error", tx_error, 0);
      end
    end
    held_v = tx_valid && !tx_ready;
    held_w = {tx_sop, tx_eop, tx_empty, tx_data};
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_sop", tx_sop, 0);
    chk("rst_fwd", fwd_cnt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rx_ready_after_rst", rx_ready, 1);
    tick();

    // 64-beat frame fills the 64-entry FIFO exactly; first beat two cycles after eop.
    send_frame(64, 6'h00, 2'd1, 1'b1, 1'b1);
    @(negedge clk);
    chk("lat_n1_valid", tx_valid, 0);
    @(negedge clk);
    chk("lat_n2_valid", tx_valid, 1);
    chk("lat_n2_sop", tx_sop, 1);
    tick();
    drain("t1");
    chk("t1_fwd", fwd_cnt, 1);

    // Errored frame, good frame, truncated frame rewound by a new sop, stray non-sop beat.
    send_frame(5, 6'h02, 2'd0, 1'b1, 1'b0);
    send_frame(4, 6'h00, 2'd2, 1'b1, 1'b1);
    send_frame(3, 6'h00, 2'd0, 1'b0, 1'b0);
    send_frame(2, 6'h00, 2'd0, 1'b1, 1'b1);
    rx_valid = 1'b1; rx_eop = 1'b1; rx_data = 32'hdead_beef; tick();
    rx_valid = 1'b0; rx_eop = 1'b0;
    drain("t2");
    chk("t2_fwd", fwd_cnt, 3);
    chk("t2_drop_err", drop_err_cnt, 2);
    chk("t2_drop_ovf", drop_ovf_cnt, 0);

    // Overflow with the sink stalled, then a frame that fits.
    tx_ready = 1'b0;
    send_frame(70, 6'h00, 2'd0, 1'b1, 1'b0);
    tick(); tick();
    @(negedge clk);
    chk("t3_no_output", tx_valid, 0);
    chk("t3_drop_ovf", drop_ovf_cnt, 1);
    tick();
    send_frame(8, 6'h00, 2'd3, 1'b1, 1'b1);
    tick(); tick(); tick();
    tx_ready = 1'b1;
    drain("t3");
    chk("t3_fwd", fwd_cnt, 4);

    // Single-beat frame.
    send_frame(1, 6'h00, 2'd3, 1'b1, 1'b1);
    drain("t4");
    chk("t4_fwd", fwd_cnt, 5);

    // Back-to-back frames under an alternating sink.
    tgl = 1'b1;
    send_frame(3, 6'h00, 2'd1, 1'b1, 1'b1);
    send_frame(5, 6'h00, 2'd0, 1'b1, 1'b1);
    send_frame(2, 6'h00, 2'd2, 1'b1, 1'b1);
    drain("t5");
    tgl = 1'b0; tx_ready = 1'b1;
    tick();
    chk("t5_fwd", fwd_cnt, 8);
    chk("t5_drop_err", drop_err_cnt, 2);

    // Reset while a frame is leaving and another is arriving.
    tx_ready = 1'b0;
    send_frame(10, 6'h00, 2'd0, 1'b1, 1'b1);
    tx_ready = 1'b1;
    send_frame(3, 6'h00, 2'd0, 1'b0, 1'b0);
    rx_valid = 1'b1; rx_data = 32'h1234_5678;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", tx_valid, 0);
    chk("t6_fwd", fwd_cnt, 0);
    chk("t6_drop_err", drop_err_cnt, 0);
    chk("t6_drop_ovf", drop_ovf_cnt, 0);
    chk("t6_rx_ready", rx_ready, 0);
    rx_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    send_frame(6, 6'h00, 2'd1, 1'b1, 1'b1);
    drain("t6");
    chk("t6_fwd_after", fwd_cnt, 1);
    chk("t6_drop_err_after", drop_err_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
